mem_clint_mh: RTL

Multi-hart, parametrised CLINT for the memory-stage MMIO path. Provides one free-running mtime with a programmable prescaler, plus per-hart mtimecmp and msip registers, all accessible through byte, half, word and dword reads and writes.
Drives registered per-hart timer (mtip) and software (msip) interrupt lines, and a one-cycle update pulse after every accepted write.
Adds a request/response handshake with back-pressure, size-aware lane merging and error responses.

---
 rtl/mem_clint_mh_pkg.sv | 47 ++++
 rtl/mem_clint_mh_if.sv | 38 +++
 rtl/mem_clint_mh_hart_timer.sv | 35 +++
 rtl/mem_clint_mh.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_clint_mh_pkg.sv
// Shared definitions for the multi-hart CLINT: offsets, size,
// response and request codes, plus lane-mask helpers.
package mem_clint_mh_pkg;

    localparam logic [63:0] OFF_MSIP     = 64'h0000;
    localparam logic [63:0] OFF_MTIMECMP = 64'h4000;
    localparam logic [63:0] OFF_MTIME    = 64'hBFF8;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] RESP_OK       = 2'b00;
    localparam logic [1:0] RESP_MISALIGN = 2'b10;
    localparam logic [1:0] RESP_DECERR   = 2'b11;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_MSIP,
        TGT_CMP,
        TGT_MTIME
    } tgt_e;

    function automatic logic [7:0] size_bytes(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic [63:0] byte_to_bit(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*8 +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_clint_mh_if.sv
// Request/response bus and interrupt lines between the
// memory stage and the CLINT.
interface mem_clint_mh_if #(
    parameter int NHARTS = 2,
    parameter int DATA_W = 64
);
    logic              clint_valid_i;
    logic              clint_ready_o;
    logic              clint_req_i;
    logic [63:0]       clint_addr_i;
    logic [1:0]        clint_size_i;
    logic [DATA_W-1:0] clint_data_write_i;
    logic              clint_resp_valid_o;
    logic              clint_resp_ready_i;
    logic [DATA_W-1:0] clint_data_read_o;
    logic [1:0]        clint_resp_o;
    logic [NHARTS-1:0] clint_mtip_o;
    logic [NHARTS-1:0] clint_msip_o;
    logic              clint_update_o;

    modport master (
        output clint_valid_i, clint_req_i, clint_addr_i,
        output clint_size_i, clint_data_write_i,
        output clint_resp_ready_i,
        input  clint_ready_o, clint_resp_valid_o,
        input  clint_data_read_o, clint_resp_o,
        input  clint_mtip_o, clint_msip_o, clint_update_o
    );

    modport slave (
        input  clint_valid_i, clint_req_i, clint_addr_i,
        input  clint_size_i, clint_data_write_i,
        input  clint_resp_ready_i,
        output clint_ready_o, clint_resp_valid_o,
        output clint_data_read_o, clint_resp_o,
        output clint_mtip_o, clint_msip_o, clint_update_o
    );
endinterface

// File: rtl/mem_clint_mh_hart_timer.sv
// Per-hart mtimecmp / msip storage with byte-masked merge
// and a registered timer-pending compare.
module clint_hart_timer #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmp_we,
    input  logic              sip_we,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wmask,
    input  logic [DATA_W-1:0] mtime,
    output logic [DATA_W-1:0] mtimecmp,
    output logic              msip,
    output logic              mtip
);

    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
            mtip     <= 1'b0;
        end else begin
            if (cmp_we) begin
                mtimecmp <= (mtimecmp & ~wmask) | (wdata & wmask);
            end
            // only bit 0 of msip is storage
            if (sip_we && wmask[0]) begin
                msip <= wdata[0];
            end
            mtip <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/mem_clint_mh.sv
// Multi-hart CLINT on the memory-stage MMIO path: decode,
// prescaled mtime, handshake and registered response.
module mem_clint_mh #(
    parameter int          NHARTS    = 2,
    parameter int          TICK_DIV  = 4,
    parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
    parameter int          DATA_W    = 64
) (
    input logic            clk,
    input logic            rst,
    mem_clint_mh_if.slave  bus
);
    import mem_clint_mh_pkg::*;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    logic [61:0]       off_hi;
    logic [60:0]       cmp_rel;
    logic              in_sip, in_cmp, in_mtime;
    logic [HW-1:0]     hart;
    tgt_e              tgt;
    logic              aligned, misalign;
    logic [2:0]        lane;
    logic [1:0]        resp_d;
    logic [DATA_W-1:0] wsh, wmask, sel_reg, rdata_d;
    logic              accept, wr_ok, mtime_we, tick;
    logic [NHARTS-1:0] cmp_we, sip_we, sip, tip;
    logic [DATA_W-1:0] cmp [NHARTS];

    logic [DATA_W-1:0] mtime;
    logic [PW-1:0]     presc;
    logic              rvalid_q, upd_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        resp_q;

    assign off_hi  = bus.clint_addr_i[63:2] - BASE_ADDR[63:2];
    assign cmp_rel = off_hi[61:1] - OFF_MTIMECMP[63:3];

    assign in_mtime = (off_hi[61:1] == OFF_MTIME[63:3]);
    assign in_cmp   = (off_hi[61:1] >= OFF_MTIMECMP[63:3])
                   && (cmp_rel < 61'(NHARTS));
    assign in_sip   = (off_hi < 62'(NHARTS));

    always_comb begin
        tgt  = TGT_NONE;
        hart = '0;
        unique case (1'b1)
            in_mtime: tgt = TGT_MTIME;
            in_cmp: begin
                tgt  = TGT_CMP;
                hart = cmp_rel[HW-1:0];
            end
            in_sip: begin
                tgt  = TGT_MSIP;
                hart = off_hi[HW-1:0];
            end
            default: tgt = TGT_NONE;
        endcase
    end

    always_comb begin
        aligned = 1'b1;
        case (bus.clint_size_i)
            SZ_B:    aligned = 1'b1;
            SZ_H:    aligned = ~bus.clint_addr_i[0];
            SZ_W:    aligned = (bus.clint_addr_i[1:0] == 2'b00);
            default: aligned = (bus.clint_addr_i[2:0] == 3'b000);
        endcase
    end

    // msip is a 32-bit register, so a dword there cannot be aligned
    assign misalign = !aligned
                   || (tgt == TGT_MSIP && bus.clint_size_i == SZ_D);

    assign lane = (tgt == TGT_MSIP) ? {1'b0, bus.clint_addr_i[1:0]}
                                    : bus.clint_addr_i[2:0];

    always_comb begin
        resp_d = RESP_OK;
        if (tgt == TGT_NONE) begin
            resp_d = RESP_DECERR;
        end else if (misalign) begin
            resp_d = RESP_MISALIGN;
        end
    end

    assign wsh   = bus.clint_data_write_i << {lane, 3'b000};
    assign wmask = byte_to_bit(size_bytes(bus.clint_size_i) << lane);

    always_comb begin
        sel_reg = '0;
        case (tgt)
            TGT_MTIME: sel_reg = mtime;
            TGT_CMP: begin
                for (int h = 0; h < NHARTS; h++) begin
                    if (hart == HW'(h)) sel_reg = cmp[h];
                end
            end
            TGT_MSIP: begin
                for (int h = 0; h < NHARTS; h++) begin
                    if (hart == HW'(h)) begin
                        sel_reg = {{(DATA_W-1){1'b0}}, sip[h]};
                    end
                end
            end
            default: sel_reg = '0;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        if (resp_d == RESP_OK) begin
            rdata_d = (sel_reg >> {lane, 3'b000})
                    & byte_to_bit(size_bytes(bus.clint_size_i));
        end
    end

    assign accept   = bus.clint_valid_i && bus.clint_ready_o;
    assign wr_ok    = accept && (bus.clint_req_i == REQ_WRITE)
                   && (resp_d == RESP_OK);
    assign mtime_we = wr_ok && (tgt == TGT_MTIME);
    assign tick     = (presc == PMAX);

    always_comb begin
        cmp_we = '0;
        sip_we = '0;
        for (int h = 0; h < NHARTS; h++) begin
            cmp_we[h] = wr_ok && (tgt == TGT_CMP) && (hart == HW'(h));
            sip_we[h] = wr_ok && (tgt == TGT_MSIP) && (hart == HW'(h));
        end
    end

    for (genvar h = 0; h < NHARTS; h++) begin : g_hart
        clint_hart_timer #(.DATA_W(DATA_W)) u_hart (
            .clk      (clk),
            .rst      (rst),
            .cmp_we   (cmp_we[h]),
            .sip_we   (sip_we[h]),
            .wdata    (wsh),
            .wmask    (wmask),
            .mtime    (mtime),
            .mtimecmp (cmp[h]),
            .msip     (sip[h]),
            .mtip     (tip[h])
        );
    end

    // a write to mtime overrides the increment of a coincident tick
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            mtime <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (mtime_we) begin
                mtime <= (mtime & ~wmask) | (wsh & wmask);
            end else if (tick) begin
                mtime <= mtime + DATA_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            resp_q   <= RESP_OK;
            upd_q    <= 1'b0;
        end else begin
            upd_q <= wr_ok;
            if (accept) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                resp_q   <= resp_d;
            end else if (bus.clint_resp_ready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign bus.clint_ready_o      = !rvalid_q || bus.clint_resp_ready_i;
    assign bus.clint_resp_valid_o = rvalid_q;
    assign bus.clint_data_read_o  = rdata_q;
    assign bus.clint_resp_o       = resp_q;
    assign bus.clint_update_o     = upd_q;
    assign bus.clint_mtip_o       = tip;
    assign bus.clint_msip_o       = sip;

endmodule
